// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit owning the MIPS HI/LO pair.
// MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring divider, both
// over XLEN iterations followed by one sign-fix/writeback cycle.
// MTHI/MTLO write HI/LO directly in the accepting cycle.
// Optional build macro MD_EARLY_TERM_EN: multiplies leave the iteration loop
// as soon as the remaining multiplier bits are all zero.
module md_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [5:0]      func,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic            busy,
    output logic            done,
    output logic            div0
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic                r_op_mul;
    logic                r_op_signed;
    logic                r_sign_a;
    logic                r_sign_b;
    logic [XLEN-1:0]     r_a_raw;
    // r_acc: product (mult) or partial remainder in the low half (div)
    logic [2*XLEN-1:0]   r_acc;
    // r_opa: shifting multiplicand (mult) or divisor in the low half (div)
    logic [2*XLEN-1:0]   r_opa;
    // r_opb: shifting multiplier (mult) or dividend turning into quotient (div)
    logic [XLEN-1:0]     r_opb;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_done;
    logic                r_div0;

    logic                w_busy;
    logic                w_is_mult;
    logic                w_is_div;
    logic                w_is_signed;
    logic                w_accept;
    logic                w_start_md;
    logic                w_mthi;
    logic                w_mtlo;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;
    logic [2*XLEN-1:0]   w_mul_acc;
    logic [XLEN:0]       w_div_shift;
    logic [XLEN:0]       w_div_trial;
    logic                w_qbit;
    logic                w_early;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix;
    logic [XLEN-1:0]     w_rem_fix;

    // Decode of the request; only recognised codes while idle are accepted
    assign w_is_mult   = (func == 6'h18) || (func == 6'h19);
    assign w_is_div    = (func == 6'h1A) || (func == 6'h1B);
    assign w_is_signed = ~func[0];
    assign w_accept    = start && !w_busy;
    assign w_start_md  = w_accept && (w_is_mult || w_is_div);
    assign w_mthi      = w_accept && (func == 6'h11);
    assign w_mtlo      = w_accept && (func == 6'h13);

    // Operand magnitudes; 0x80000000 maps to itself, which is the correct unsigned magnitude
    assign w_abs_a = (w_is_signed && rs_data[XLEN-1]) ? (~rs_data + 1'b1) : rs_data;
    assign w_abs_b = (w_is_signed && rt_data[XLEN-1]) ? (~rt_data + 1'b1) : rt_data;

    // One shift-add / restoring-divide step
    assign w_mul_acc   = r_opb[0] ? (r_acc + r_opa) : r_acc;
    assign w_div_shift = {r_acc[XLEN-1:0], r_opb[XLEN-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opa[XLEN-1:0]};
    assign w_qbit      = ~w_div_trial[XLEN];

`ifdef MD_EARLY_TERM_EN
    assign w_early = r_op_mul && (r_opb == '0);
`else
    assign w_early = 1'b0;
`endif

    // Sign correction applied in the writeback cycle
    assign w_prod_fix = (r_op_signed && (r_sign_a ^ r_sign_b)) ? (~r_acc + 1'b1) : r_acc;
    assign w_quot_fix = (r_op_signed && (r_sign_a ^ r_sign_b)) ? (~r_opb + 1'b1) : r_opb;
    assign w_rem_fix  = (r_op_signed && r_sign_a) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE -> CALC on a mult/div, CALC -> FIX on last step, FIX -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_md) w_state_next = S_CALC;
            S_CALC:  if (w_early || (r_cnt == CW'(1))) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs derived from state and status registers
    always_comb begin
        w_busy = (r_state != S_IDLE);
        busy   = w_busy;
        done   = r_done;
        div0   = r_div0;
        HI     = r_hi;
        LO     = r_lo;
    end

    // Datapath: operand latch, iteration, sign fix and HI/LO writeback
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt       <= '0;
            r_op_mul    <= 1'b0;
            r_op_signed <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_a_raw     <= '0;
            r_acc       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_div0      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_md) begin
                        r_op_mul    <= w_is_mult;
                        r_op_signed <= w_is_signed;
                        r_sign_a    <= w_is_signed & rs_data[XLEN-1];
                        r_sign_b    <= w_is_signed & rt_data[XLEN-1];
                        r_a_raw     <= rs_data;
                        r_div0      <= w_is_div && (rt_data == '0);
                        r_acc       <= '0;
                        r_cnt       <= CW'(XLEN);
                        if (w_is_mult) begin
                            r_opa <= {{XLEN{1'b0}}, w_abs_a};
                            r_opb <= w_abs_b;
                        end else begin
                            r_opa <= {{XLEN{1'b0}}, w_abs_b};
                            r_opb <= w_abs_a;
                        end
                    end else if (w_mthi) begin
                        r_hi <= rs_data;
                    end else if (w_mtlo) begin
                        r_lo <= rs_data;
                    end
                end
                S_CALC: begin
                    if (!w_early) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_op_mul) begin
                            r_acc <= w_mul_acc;
                            r_opa <= r_opa << 1;
                            r_opb <= r_opb >> 1;
                        end else begin
                            r_acc <= {{XLEN{1'b0}},
                                      w_qbit ? w_div_trial[XLEN-1:0] : w_div_shift[XLEN-1:0]};
                            r_opb <= {r_opb[XLEN-2:0], w_qbit};
                        end
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_op_mul) begin
                        r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                        r_lo <= w_prod_fix[XLEN-1:0];
                    end else if (r_div0) begin
                        // Divide by zero reports all-ones quotient and the untouched dividend
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: vector table of mult/div ops plus hand-written
// sequences for MTHI/MTLO, busy-time requests, back-to-back starts and reset.
module tb_md_sequencer;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [5:0]  func;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        div0;

    int n_checks = 0;
    int n_fail   = 0;

    md_sequencer #(.XLEN(32)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .func    (func),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy),
        .done    (done),
        .div0    (div0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  func;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected edges from acceptance to HI/LO update
    function automatic int exp_lat(input logic [5:0] f, input logic [31:0] rt);
        int iters;
        iters = 32;
`ifdef MD_EARLY_TERM_EN
        if (f == 6'h18 || f == 6'h19) begin
            iters = 0;
            for (int b = 0; b < 32; b++) if (rt[b]) iters = b + 1;
        end
`else
        if (f == 6'h00) iters = 32;
`endif
        return (iters < 32) ? iters + 2 : 33;
    endfunction

    // Called at posedge+1: issue an op, count edges until done and busy-high samples
    task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        start   = 1'b1;
        func    = f;
        rs_data = a;
        rt_data = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 80) begin
            if (busy) bcnt++;
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 80) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check(name, {63'd0, done}, 64'd1);
    endtask

    int lat;
    int bcnt;

    initial begin
        vecs[0]  = '{6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[2]  = '{6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{6'h1A, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{6'h19, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[5]  = '{6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[6]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{6'h19, 32'd5,        32'd0,        32'd0,        32'd0,        1'b0};
        vecs[8]  = '{6'h19, 32'd5,        32'd1,        32'd0,        32'd5,        1'b0};
        vecs[9]  = '{6'h1B, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[10] = '{6'h1A, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[11] = '{6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[12] = '{6'h1A, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[13] = '{6'h18, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};

        RST     = 1'b0;
        start   = 1'b0;
        func    = 6'h00;
        rs_data = '0;
        rt_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_hi",   {32'd0, HI}, 64'd0);
        check("reset_lo",   {32'd0, LO}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_div0", {63'd0, div0}, 64'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // MTHI / MTLO: single-edge writes, no busy or done
        start = 1'b1; func = 6'h11; rs_data = 32'hA5A5A5A5;
        @(posedge CLK);
        #1;
        start = 1'b0;
        $display("mthi rs=%h -> HI=%h busy=%b done=%b", 32'hA5A5A5A5, HI, busy, done);
        check("mthi_hi",   {32'd0, HI}, {32'd0, 32'hA5A5A5A5});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_done", {63'd0, done}, 64'd0);
        start = 1'b1; func = 6'h13; rs_data = 32'h5A5A5A5A;
        @(posedge CLK);
        #1;
        start = 1'b0;
        $display("mtlo rs=%h -> LO=%h HI=%h", 32'h5A5A5A5A, LO, HI);
        check("mtlo_lo", {32'd0, LO}, {32'd0, 32'h5A5A5A5A});
        check("mtlo_hi", {32'd0, HI}, {32'd0, 32'hA5A5A5A5});

        // Unrecognised func is ignored
        start = 1'b1; func = 6'h20; rs_data = 32'h11111111; rt_data = 32'h2;
        @(posedge CLK);
        #1;
        start = 1'b0;
        $display("bad func 20 -> busy=%b HI=%h LO=%h", busy, HI, LO);
        check("badfunc_busy", {63'd0, busy}, 64'd0);
        check("badfunc_hi", {32'd0, HI}, {32'd0, 32'hA5A5A5A5});
        check("badfunc_lo", {32'd0, LO}, {32'd0, 32'h5A5A5A5A});

        // Vector table
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].func, vecs[i].rs, vecs[i].rt, lat, bcnt);
            $display("vec %0d func=%h rs=%h rt=%h -> HI=%h LO=%h div0=%b lat=%0d busy=%0d",
                     i, vecs[i].func, vecs[i].rs, vecs[i].rt, HI, LO, div0, lat, bcnt);
            check($sformatf("vec%0d_done", i), {63'd0, done}, 64'd1);
            check($sformatf("vec%0d_hi", i), {32'd0, HI}, {32'd0, vecs[i].hi});
            check($sformatf("vec%0d_lo", i), {32'd0, LO}, {32'd0, vecs[i].lo});
            check($sformatf("vec%0d_div0", i), {63'd0, div0}, {63'd0, vecs[i].dz});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].func, vecs[i].rt)));
            check($sformatf("vec%0d_busycyc", i), 64'(bcnt), 64'(exp_lat(vecs[i].func, vecs[i].rt)));
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // div0 clears at acceptance of the next mult/div
        do_op(6'h1B, 32'd5, 32'd0, lat, bcnt);
        check("dz_set", {63'd0, div0}, 64'd1);
        start = 1'b1; func = 6'h19; rs_data = 32'd2; rt_data = 32'd3;
        @(posedge CLK);
        #1;
        start = 1'b0;
        $display("divu 5/0 then multu 2*3 accepted -> div0=%b busy=%b", div0, busy);
        check("dz_clear", {63'd0, div0}, 64'd0);
        wait_done("dz_next_done");
        check("dz_next_lo", {32'd0, LO}, 64'd6);

        // MTLO during busy is ignored
        start = 1'b1; func = 6'h19; rs_data = 32'd3; rt_data = 32'h80000005;
        @(posedge CLK);
        #1;
        repeat (4) @(posedge CLK);
        #1;
        start = 1'b1; func = 6'h13; rs_data = 32'd1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done("busy_ign_done");
        $display("multu 3*80000005 with mtlo during busy -> HI=%h LO=%h", HI, LO);
        check("busy_ign_hi", {32'd0, HI}, 64'd1);
        check("busy_ign_lo", {32'd0, LO}, {32'd0, 32'h8000000F});

        // New start in the done cycle is accepted
        start = 1'b1; func = 6'h1B; rs_data = 32'd100; rt_data = 32'd7;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_done("b2b_done");
        $display("back-to-back divu 100/7 -> HI=%h LO=%h", HI, LO);
        check("b2b_hi", {32'd0, HI}, 64'd2);
        check("b2b_lo", {32'd0, LO}, 64'd14);
        @(posedge CLK);
        #1;

        // Reset in the middle of a multiply
        start = 1'b1; func = 6'h18; rs_data = 32'h1234; rt_data = 32'h5678;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        $display("reset mid-op -> HI=%h LO=%h busy=%b done=%b", HI, LO, busy, done);
        check("midrst_hi",   {32'd0, HI}, 64'd0);
        check("midrst_lo",   {32'd0, LO}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        do_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        $display("post-reset multu ffffffff^2 -> HI=%h LO=%h lat=%0d", HI, LO, lat);
        check("postrst_hi", {32'd0, HI}, {32'd0, 32'hFFFFFFFE});
        check("postrst_lo", {32'd0, LO}, 64'd1);
        check("postrst_lat", 64'(lat), 64'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
